stage_if: RTL
=============

// Module: stage_if
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of stage_id.
//  Owns the PC, drives a variable-latency instruction-memory req/ready port, and registers {instr, pc_id} into IF/ID.
//  Honours stall (hold IF/ID) from the hazard unit and taken-branch redirect (flush IF/ID) from EX/MEM.
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset (bits[1:0] must be 0)
//  NOP_INSTR  32'h0000_0000  instruction word injected on bubble/flush (sll $0,$0,0)
// PORTS
//  clock         in   1   pipeline clock, all state on posedge
//  reset         in   1   synchronous, active-low; sampled on posedge clock
//  stall         in   1   hazard unit: IF/ID and PC must hold this cycle
//  branchTaken   in   1   redirect request (branch/jump resolved downstream)
//  branchTarget  in   32  redirect address; bits[1:0] ignored (forced 00)
//  imemReq       out  1   fetch request valid
//  imemAddr      out  32  fetch address; stable while imemReq=1 and imemReady=0
//  imemReady     in   1   memory returns imemData this cycle (completes request)
//  imemData      in   32  instruction word, valid only when imemReady=1
//  instr         out  32  IF/ID register: instruction to stage_id
//  pc_id         out  32  IF/ID register: fetch address + 4 of that instruction
//  valid_id      out  1   IF/ID register: 1 = real instruction, 0 = bubble
// BEHAVIOUR
//  Reset (reset=0): pc=RESET_PC, fetchAddr=RESET_PC, state=FETCH, instr=NOP_INSTR, pc_id=0, valid_id=0, hold buffer cleared.
//  First imemReq=1 on the cycle after reset releases. All outputs registered; imemReq/imemAddr decoded from state/fetchAddr only.
//  FSM states:
//   FETCH: imemReq=1, imemAddr=fetchAddr (==pc).
//   DROP : imemReq=1, imemAddr=fetchAddr (stale); response will be discarded.
//   HOLD : imemReq=0; fetched word parked in hold buffer {hInstr,hPc}.
//  Priority per cycle: reset > branchTaken > stall > normal.
//  branchTaken=1 (any state, overrides stall): IF/ID <= {NOP_INSTR, 0, valid 0}; pc <= {branchTarget[31:2],2'b00}; hold buffer discarded.
//   FETCH & !imemReady -> DROP (fetchAddr unchanged). FETCH & imemReady -> data discarded, fetchAddr<=target, FETCH.
//   DROP: stays DROP until imemReady. HOLD -> FETCH, fetchAddr<=target.
//  stall=1, no branch: IF/ID holds all three fields.
//   FETCH & imemReady -> hold buffer <= {imemData, fetchAddr+4}, pc/fetchAddr += 4, -> HOLD. FETCH & !imemReady -> FETCH.
//   HOLD -> HOLD. DROP & imemReady -> FETCH, fetchAddr<=pc.
//  Normal (no stall, no branch):
//   FETCH & imemReady: IF/ID <= {imemData, fetchAddr+4, 1}; pc/fetchAddr += 4 (back-to-back fetch, 1 instr/cycle at 1-cycle memory).
//   FETCH & !imemReady: IF/ID <= bubble {NOP_INSTR, 0, 0}.
//   HOLD: IF/ID <= {hInstr, hPc, 1}; -> FETCH (new request issued next cycle).
//   DROP: IF/ID <= bubble; imemReady -> FETCH, fetchAddr<=pc.
//  Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0, no flag.
//  Reset mid-request: outstanding response is abandoned; memory side must tolerate req drop on reset.
//  Invariant: at most one request outstanding; no instruction duplicated or lost across stall/redirect.
// CONFIGURATION
//  Macro STAGE_IF_PERF_CNT_EN:
//   defined: adds outputs fetchCount[31:0] (increments per word written to IF/ID with valid_id=1)
//            and bubbleCount[31:0] (increments per bubble written, incl. flushes); both reset to 0, wrap at 2^32.
//   undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package mips_pkg: NOP_INSTR, RESET_PC default, state encoding (IF_FETCH=2'd0, IF_DROP=2'd1, IF_HOLD=2'd2).
//  Sub-module fetch_ctrl: FSM + pc/fetchAddr update; stage_if top holds IF/ID regs, hold buffer, counters.
// TESTING
//  1-cycle memory (imemReady=1 always), no stall: after reset instr words at 0,4,8 appear on consecutive cycles, pc_id=4,8,12, valid_id=1.
//  stall=1 for 3 cycles with ready: IF/ID frozen, one word parked in HOLD, imemReq=0; on release next word issued in order, none lost/duplicated.
//  imemReady low 2 cycles at addr 0x10: imemAddr stays 0x10, two bubbles (valid_id=0, instr=0), then word from 0x10 with pc_id=0x14.
//  branchTaken with target 0x103 while request to 0x20 pending (ready 2 cycles later): IF/ID flushed, 0x20 data discarded, next fetch 0x100.
//  branchTaken and stall same cycle in HOLD: flush wins, valid_id=0, next imemAddr=target.
//  RESET_PC=32'hFFFF_FFFC: second fetch address is 0x0; with STAGE_IF_PERF_CNT_EN, after 10 valid + 3 bubbles fetchCount=10, bubbleCount=3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline fetch stage: default constants,
// fetch FSM state encoding and small address helpers.
package mips_pkg;

  // sll $0,$0,0 -- the canonical MIPS no-op used for bubbles and flushes
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,  // request outstanding at fetchAddr (== pc)
    IF_DROP  = 2'd1,  // stale request outstanding, response will be discarded
    IF_HOLD  = 2'd2   // no request, fetched word parked in hold buffer
  } if_state_e;

  // Sequential instruction address; wraps modulo 2^32 without a flag
  function automatic logic [31:0] pc_plus4(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  // Redirect targets are forced to word alignment
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/stage_if_fetch_ctrl.sv
// Fetch controller: owns pc / fetchAddr and the FETCH/DROP/HOLD state
// machine. Emits one-hot IF/ID update strobes for the top level.
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] seq_addr,
  output logic        load_o,
  output logic        park_o,
  output logic        unpark_o,
  output logic        bubble_o
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] target;

  assign target    = word_align(branch_target);
  assign imem_req  = (state_q != IF_HOLD);
  assign imem_addr = fetch_addr_q;
  assign seq_addr  = pc_plus4(fetch_addr_q);

  // Next-state, pc/fetchAddr update and IF/ID strobes; branch beats stall
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    load_o       = 1'b0;
    park_o       = 1'b0;
    unpark_o     = 1'b0;
    bubble_o     = 1'b0;
    if (branch_taken) begin
      bubble_o = 1'b1;
      pc_d     = target;
      case (state_q)
        IF_FETCH: begin
          // A pending request cannot be retracted; let it drain in DROP
          if (imem_ready) fetch_addr_d = target;
          else            state_d      = IF_DROP;
        end
        IF_DROP: begin
          if (imem_ready) begin
            state_d      = IF_FETCH;
            fetch_addr_d = target;
          end
        end
        default: begin
          state_d      = IF_FETCH;
          fetch_addr_d = target;
        end
      endcase
    end else if (stall) begin
      case (state_q)
        IF_FETCH: begin
          if (imem_ready) begin
            park_o       = 1'b1;
            pc_d         = pc_plus4(pc_q);
            fetch_addr_d = pc_plus4(fetch_addr_q);
            state_d      = IF_HOLD;
          end
        end
        IF_DROP: begin
          if (imem_ready) begin
            state_d      = IF_FETCH;
            fetch_addr_d = pc_q;
          end
        end
        default: state_d = IF_HOLD;
      endcase
    end else begin
      case (state_q)
        IF_FETCH: begin
          if (imem_ready) begin
            load_o       = 1'b1;
            pc_d         = pc_plus4(pc_q);
            fetch_addr_d = pc_plus4(fetch_addr_q);
          end else begin
            bubble_o = 1'b1;
          end
        end
        IF_DROP: begin
          bubble_o = 1'b1;
          if (imem_ready) begin
            state_d      = IF_FETCH;
            fetch_addr_d = pc_q;
          end
        end
        default: begin
          unpark_o = 1'b1;
          state_d  = IF_FETCH;
        end
      endcase
    end
  end

  // State, pc and fetch address registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IF_FETCH;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC, variable-latency imem port and IF/ID register.
// Optional build macro STAGE_IF_PERF_CNT_EN adds fetchCount/bubbleCount.
module stage_if
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] instr,
  output logic [31:0] pc_id,
  output logic        valid_id
`ifdef STAGE_IF_PERF_CNT_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] bubbleCount
`endif
);

  logic [31:0] seq_addr;
  logic        load, park, unpark, bubble;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        valid_q, valid_d;
  logic [31:0] h_instr_q, h_instr_d;
  logic [31:0] h_pc_q, h_pc_d;

  fetch_ctrl #(
    .RESET_PC (RESET_PC)
  ) u_fetch_ctrl (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branchTaken),
    .branch_target (branchTarget),
    .imem_ready    (imemReady),
    .imem_req      (imemReq),
    .imem_addr     (imemAddr),
    .seq_addr      (seq_addr),
    .load_o        (load),
    .park_o        (park),
    .unpark_o      (unpark),
    .bubble_o      (bubble)
  );

  // IF/ID and hold-buffer next values; untouched fields hold (stall)
  always_comb begin
    instr_d   = instr_q;
    pc_id_d   = pc_id_q;
    valid_d   = valid_q;
    h_instr_d = h_instr_q;
    h_pc_d    = h_pc_q;
    if (bubble) begin
      instr_d = NOP_INSTR;
      pc_id_d = '0;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = imemData;
      pc_id_d = seq_addr;
      valid_d = 1'b1;
    end else if (unpark) begin
      instr_d = h_instr_q;
      pc_id_d = h_pc_q;
      valid_d = 1'b1;
    end
    if (park) begin
      h_instr_d = imemData;
      h_pc_d    = seq_addr;
    end else if (branchTaken) begin
      h_instr_d = '0;
      h_pc_d    = '0;
    end
  end

  // IF/ID and hold-buffer registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      instr_q   <= NOP_INSTR;
      pc_id_q   <= '0;
      valid_q   <= 1'b0;
      h_instr_q <= '0;
      h_pc_q    <= '0;
    end else begin
      instr_q   <= instr_d;
      pc_id_q   <= pc_id_d;
      valid_q   <= valid_d;
      h_instr_q <= h_instr_d;
      h_pc_q    <= h_pc_d;
    end
  end

  assign instr    = instr_q;
  assign pc_id    = pc_id_q;
  assign valid_id = valid_q;

`ifdef STAGE_IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Count words and bubbles actually written into IF/ID
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'd0, (load | unpark)};
    bubble_cnt_d = bubble_cnt_q + {31'd0, bubble};
  end

  // Performance counter registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetchCount  = fetch_cnt_q;
  assign bubbleCount = bubble_cnt_q;
`endif

endmodule
